window_loader: RTL

//  Memory-fetch stage that directly feeds convolution_layer.
//  On a load request (base address, square size S), it reads S*S consecutive words from a

---
 rtl/window_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/window_loader.sv
// window_loader: fetches an S x S window of consecutive words from a single-port
// RAM (1-cycle read latency) into a parallel row-major buffer for the conv stage.
//
// state | meaning
// IDLE  | waiting for load_en; base and word count latched on accept
// READ  | one RAM read issued per cycle, previous read's data captured
// DRAIN | no read issued; last outstanding word captured
// DONE  | buffer complete, load_done pulsed; load_en ignored here
module window_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_size,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] load_out [0:MAX_WORDS-1],
    output logic              load_done,
    output logic              busy,
    output logic              size_err
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam logic [2*DATA_W-1:0] MAX_SQ = (2*DATA_W)'(MAX_WORDS);
    localparam logic [CNT_W-1:0]    MAX_N  = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [2*DATA_W-1:0] size_wide;
    logic [2*DATA_W-1:0] size_sq;
    logic                over_size;
    logic [CNT_W-1:0]    n_req;
    logic                accept;

    logic [ADDR_W-1:0]   base;
    logic [CNT_W-1:0]    remaining;
    logic [IDX_W-1:0]    idx;
    logic                rd_pend;
    logic [IDX_W-1:0]    wr_idx;

    // Square is formed at double width so large S cannot alias into a small count.
    assign size_wide = {{DATA_W{1'b0}}, load_size};
    assign size_sq   = size_wide * size_wide;
    assign over_size = size_sq > MAX_SQ;
    assign n_req     = over_size ? MAX_N : size_sq[CNT_W-1:0];
    assign accept    = (state == IDLE) && load_en;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore outputs; reads are issued straight from the READ state.
    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        load_done = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nx = (n_req == '0) ? DONE : READ;
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = base + {{(ADDR_W-IDX_W){1'b0}}, idx};
                if (remaining == '0) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request latch, terminal-count down-counter and read-index tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            base      <= '0;
            remaining <= '0;
            idx       <= '0;
            rd_pend   <= 1'b0;
            wr_idx    <= '0;
            size_err  <= 1'b0;
        end else begin
            rd_pend <= mem_rd_en;
            wr_idx  <= idx;
            if (accept) begin
                base      <= load_addr;
                remaining <= n_req - CNT_W'(1);
                idx       <= '0;
                size_err  <= over_size;
            end else if (state == READ) begin
                remaining <= remaining - CNT_W'(1);
                idx       <= idx + IDX_W'(1);
            end
        end
    end

    // Capture the word returned for the previous cycle's read; untouched entries keep data.
    always_ff @(posedge clk) begin
        if (!reset && rd_pend) begin
            load_out[wr_idx] <= mem_rdata;
        end
    end

endmodule
